ecc_scrub_ctrl: RTL

Background scrubber controller for the 32-bit single-error-correcting corrector (32 data + 8 check bits in, 32 corrected data out, check-enable input). On each pass it reads every word of a protected memory and passes it through the corrector. It writes corrected words back and counts corrections. A host port shares the single memory port with the scrubber, and the scrubber yields to it between words.

---
 rtl/ecc_scrub_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ecc_scrub_ctrl.sv
`timescale 1ns/1ps
// ecc_scrub_ctrl: background ECC scrubber that shares one memory port with a host.
// Define SCRUB_ERRLOG_EN to record the address of the last corrected word in err_addr.
module ecc_scrub_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              host_req,
    output logic              host_gnt,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [39:0]       mem_wr_data,
    input  logic [39:0]       mem_rd_data,
    output logic [31:0]       cor_data,
    output logic [7:0]        cor_chk,
    output logic              cor_en,
    input  logic [31:0]       cor_out,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_CHK,
        ST_WB,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] addr;
    logic [39:0]       word_q;
    logic [31:0]       fix_q;
    logic              last;

    assign last     = (addr == ADDR_W'(DEPTH - 1));
    assign host_gnt = host_req & (state == ST_IDLE || state == ST_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next        = state;
        busy        = (state != ST_IDLE);
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        cor_data    = '0;
        cor_chk     = '0;
        cor_en      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) next = ST_RD;
            end
            ST_RD: begin
                // The host wins the port; the read is simply deferred.
                if (!host_req) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = addr;
                    next      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                next = ST_CHK;
            end
            ST_CHK: begin
                cor_en   = 1'b1;
                cor_data = word_q[31:0];
                cor_chk  = word_q[39:32];
                next     = (cor_out != word_q[31:0]) ? ST_WB : ST_NEXT;
            end
            ST_WB: begin
                mem_wr_en   = 1'b1;
                mem_addr    = addr;
                mem_wr_data = {word_q[39:32], fix_q};
                next        = ST_NEXT;
            end
            ST_NEXT: begin
                next = last ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done = 1'b1;
                next = ST_IDLE;
            end
            default: begin
                next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            word_q   <= '0;
            fix_q    <= '0;
            corr_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr     <= '0;
                        corr_cnt <= '0;
                    end
                end
                ST_WAIT: word_q <= mem_rd_data;
                ST_CHK:  fix_q  <= cor_out;
                ST_WB: begin
                    if (corr_cnt != {CNT_W{1'b1}}) corr_cnt <= corr_cnt + CNT_W'(1);
                end
                ST_NEXT: begin
                    if (!last) addr <= addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SCRUB_ERRLOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= '0;
        end else if (state == ST_WB) begin
            err_addr <= addr;
        end
    end
`else
    assign err_addr = '0;
`endif

endmodule
